// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined add/subtract unit.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  function automatic bit stages_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple-carry slice; Cmsb is the carry into the slice MSB.
module adder_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             Cin,
  output logic [CHUNK-1:0] Sum,
  output logic             Cout,
  output logic             Cmsb
);

  logic [CHUNK:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < CHUNK; i++) begin : gen_bit
    fulladder u_fa (
      .A    (A[i]),
      .B    (B[i]),
      .Cin  (carry[i]),
      .Sum  (Sum[i]),
      .Cout (carry[i+1])
    );
  end

  assign Cout = carry[CHUNK];
  assign Cmsb = carry[CHUNK-1];

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell.
module fulladder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/pipelined_adder.sv
// Add/subtract unit whose carry chain ripples one CHUNK-bit slice per pipeline stage,
// with valid/ready flow control and bubble collapsing between stages.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (!stages_ok(WIDTH, STAGES)) begin : gen_bad_params
    $error("pipelined_adder: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_carry;
  logic [STAGES-1:0] load;
  logic              downstream;
  logic [WIDTH-1:0]  rem_a    [STAGES];
  logic [WIDTH-1:0]  rem_b    [STAGES];
  logic [WIDTH-1:0]  part_sum [STAGES];
  logic              last_ovf;

  // Subtraction becomes addition of the complemented operand and borrow.
  assign b_eff   = (op == OP_SUB) ? ~B : B;
  assign cin_eff = (op == OP_SUB) ? ~Cin : Cin;

  // A stage may load when empty or when its successor takes its contents this cycle.
  always_comb begin
    load       = '0;
    downstream = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      load[k]    = !stage_valid[k] || downstream;
      downstream = load[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    logic [WIDTH-1:0] a_in, b_in, s_in, s_next;
    logic             c_in, v_in;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout, slice_cmsb;
    logic             valid_q, carry_q;
    logic [WIDTH-1:0] sum_q;

    if (k == 0) begin : gen_first
      assign a_in = A;
      assign b_in = b_eff;
      assign c_in = cin_eff;
      assign s_in = '0;
      assign v_in = in_valid;
    end else begin : gen_rest
      assign a_in = rem_a[k-1];
      assign b_in = rem_b[k-1];
      assign c_in = stage_carry[k-1];
      assign s_in = part_sum[k-1];
      assign v_in = stage_valid[k-1];
    end

    adder_slice #(
      .CHUNK (CHUNK)
    ) u_slice (
      .A    (a_in[CHUNK-1:0]),
      .B    (b_in[CHUNK-1:0]),
      .Cin  (c_in),
      .Sum  (slice_sum),
      .Cout (slice_cout),
      .Cmsb (slice_cmsb)
    );

    always_comb begin
      s_next                     = s_in;
      s_next[k*CHUNK +: CHUNK]   = slice_sum;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (load[k]) begin
        valid_q <= v_in;
      end
    end

    always_ff @(posedge clk) begin
      if (load[k] && v_in) begin
        sum_q   <= s_next;
        carry_q <= slice_cout;
      end
    end

    assign stage_valid[k] = valid_q;
    assign stage_carry[k] = carry_q;
    assign part_sum[k]    = sum_q;

    if (k < STAGES - 1) begin : gen_fwd
      // Remaining operand slices shift down so the next slice is always at the bottom.
      logic [WIDTH-1:0] a_q, b_q;
      logic             unused_cmsb;

      always_ff @(posedge clk) begin
        if (load[k] && v_in) begin
          a_q <= a_in >> CHUNK;
          b_q <= b_in >> CHUNK;
        end
      end

      assign rem_a[k]    = a_q;
      assign rem_b[k]    = b_q;
      assign unused_cmsb = slice_cmsb;
    end else begin : gen_last
      logic ovf_q;
      logic unused_rem;

      always_ff @(posedge clk) begin
        if (load[k] && v_in) begin
          ovf_q <= slice_cout ^ slice_cmsb;
        end
      end

      assign last_ovf   = ovf_q;
      assign rem_a[k]   = '0;
      assign rem_b[k]   = '0;
      assign unused_rem = ^{a_in, b_in};
    end
  end

  assign in_ready  = load[0];
  assign out_valid = stage_valid[STAGES-1];
  assign Sum       = part_sum[STAGES-1];
  assign Cout      = stage_carry[STAGES-1];
  assign Ovf       = last_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed and random beats against a
// plain-arithmetic reference model, with backpressure and mid-flight reset.
module tb_pipelined_adder;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, op, cout, ovf;

  res_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   emitted = 0;
  int   accepted = 0;
  logic held = 1'b0;
  res_t held_v;

  always #5 clk = ~clk;

  pipelined_adder #(
    .WIDTH  (W),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (sum),
    .Cout      (cout),
    .Ovf       (ovf)
  );

  // Reference: unsigned range for carry/borrow, signed range for overflow.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic o);
    longint ux  = x;
    longint uy  = y;
    longint sx  = $signed(x);
    longint sy  = $signed(y);
    longint lim = longint'(1) << (W - 1);
    longint r, sr;
    res_t   m;
    if (o == 1'b0) begin
      r      = ux + uy + c;
      sr     = sx + sy + c;
      m.cout = (r >= 2 * lim);
    end else begin
      r      = ux - uy - c;
      sr     = sx - sy - c;
      m.cout = (ux >= uy + c);
    end
    m.sum = W'(r);
    m.ovf = (sr >= lim) || (sr < -lim);
    return m;
  endfunction

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, score the handshakes, return at the next negedge.
  task automatic cycle(input logic iv, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic o, input logic ordy);
    res_t got;
    res_t e;
    in_valid  = iv;
    a         = x;
    b         = y;
    cin       = c;
    op        = o;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      got = {sum, cout, ovf};
      emitted++;
      total++;
      assert (expq.size() != 0) else begin
        bad++;
        $error("FAIL spurious_result observed=%h expected=no_result", got);
      end
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("result", 64'(got), 64'(e));
      end
    end
    if (in_valid && in_ready) begin
      expq.push_back(model(x, y, c, o));
      accepted++;
    end
    held   = out_valid && !out_ready;
    held_v = {sum, cout, ovf};
    @(negedge clk);
    if (held && !rst) chk("hold_stable", 64'({out_valid, sum, cout, ovf}), 64'({1'b1, held_v}));
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4 * int'(S) + 20 && expq.size() != 0; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    end
    chk(tag, 64'(expq.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2, 1'b0);
    rst = 1'b0;
    held = 1'b0;
    expq.delete();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
  endtask

  logic [W-1:0] da[6];
  logic [W-1:0] db[6];
  logic         dc[6];
  logic         dop[6];

  initial begin
    int k, acc0, em0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed beats; the first one also measures latency.
    da[0] = W'(16'h1234); db[0] = W'(16'h4321); dc[0] = 1'b0; dop[0] = 1'b0;
    da[1] = W'(16'hFFFF); db[1] = W'(16'h0001); dc[1] = 1'b0; dop[1] = 1'b0;
    da[2] = W'(16'h7FFF); db[2] = W'(16'h0001); dc[2] = 1'b0; dop[2] = 1'b0;
    da[3] = W'(16'h0005); db[3] = W'(16'h0007); dc[3] = 1'b0; dop[3] = 1'b1;
    da[4] = W'(16'h8000); db[4] = W'(16'h0001); dc[4] = 1'b0; dop[4] = 1'b1;
    da[5] = W'(16'h0010); db[5] = W'(16'h0003); dc[5] = 1'b1; dop[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      acc0 = accepted;
      cycle(1'b1, da[i], db[i], dc[i], dop[i], 1'b1);
      chk("directed_accept", 64'(accepted - acc0), 64'd1);
      if (i == 0) begin
        k = 1;
        while (!out_valid && k < int'(S) + 4) begin
          idle(1, 1'b1);
          k++;
        end
        chk("latency", 64'(k), 64'(S));
      end
      drain("directed_drain");
    end

    // Back-to-back random beats with the consumer always ready.
    acc0 = accepted;
    em0  = emitted;
    for (int i = 0; i < 20; i++) cycle(1'b1, rnd(), rnd(), 1'($urandom), 1'($urandom), 1'b1);
    chk("b2b_accepted", 64'(accepted - acc0), 64'd20);
    idle(int'(S), 1'b1);
    chk("b2b_emitted", 64'(emitted - em0), 64'd20);
    chk("b2b_queue", 64'(expq.size()), 64'd0);

    // Stall: the pipe fills to exactly S beats, then in_ready drops.
    acc0 = accepted;
    for (int i = 0; i < int'(S) + 2; i++) begin
      cycle(1'b1, rnd(), rnd(), 1'($urandom), 1'($urandom), 1'b0);
    end
    chk("stall_accepted", 64'(accepted - acc0), 64'(S));
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    drain("stall_drain");

    // Random producer and consumer.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rnd(), rnd(), 1'($urandom), 1'($urandom),
            1'($urandom));
    end
    drain("random_drain");

    // Reset with beats in flight: nothing stale may come out afterwards.
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd(), rnd(), 1'($urandom), 1'($urandom), 1'b1);
    em0 = emitted;
    do_reset();
    idle(int'(S) + 3, 1'b1);
    chk("no_stale", 64'(emitted - em0), 64'd0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'($urandom), rnd(), rnd(), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    drain("post_reset_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
